// File: rtl/sc_comp_dataflow.sv
// sc_comp_dataflow: single-cycle MIPS subset computer.
// Instruction ROM, data RAM and the processor core with its register file.
// One instruction completes on every rising clock edge.

module sc_regfile (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b
);
    logic [31:0] array_reg [31:0];

    // Reset clears every register; otherwise commit one write, never to $0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) array_reg[i] <= '0;
        end else if (i_we && (i_waddr != 5'd0)) begin
            array_reg[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'd0 : array_reg[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'd0 : array_reg[i_raddr_b];
endmodule

module sc_cpu (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_dm_rdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_alu,
    output logic        o_dm_we,
    output logic [31:0] o_dm_wdata
);
    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

    logic [31:0] r_pc;
    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd, w_sh, w_waddr;
    logic [31:0] w_a, w_b, w_sext, w_zext, w_pc4, w_btgt, w_jtgt;
    logic [31:0] w_alu, w_npc, w_wdata;
    logic        w_we, w_dm_we, w_ld, w_link;

    assign w_op   = i_inst[31:26];
    assign w_rs   = i_inst[25:21];
    assign w_rt   = i_inst[20:16];
    assign w_rd   = i_inst[15:11];
    assign w_sh   = i_inst[10:6];
    assign w_fn   = i_inst[5:0];
    assign w_sext = {{16{i_inst[15]}}, i_inst[15:0]};
    assign w_zext = {16'h0000, i_inst[15:0]};
    assign w_pc4  = r_pc + 32'd4;
    assign w_btgt = w_pc4 + {w_sext[29:0], 2'b00};
    assign w_jtgt = {w_pc4[31:28], i_inst[25:0], 2'b00};

    sc_regfile cpu_ref (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_a),
        .o_rdata_b (w_b)
    );

    // Decode and execute: ALU result, write-back control and next PC; unknown encodings fall through as NOP
    always_comb begin
        w_alu   = '0;
        w_we    = 1'b0;
        w_waddr = w_rd;
        w_dm_we = 1'b0;
        w_ld    = 1'b0;
        w_link  = 1'b0;
        w_npc   = w_pc4;
        case (w_op)
            6'h00: begin
                w_we = 1'b1;
                case (w_fn)
                    6'h20, 6'h21: w_alu = w_a + w_b;
                    6'h22, 6'h23: w_alu = w_a - w_b;
                    6'h24:        w_alu = w_a & w_b;
                    6'h25:        w_alu = w_a | w_b;
                    6'h26:        w_alu = w_a ^ w_b;
                    6'h27:        w_alu = ~(w_a | w_b);
                    6'h2A:        w_alu = {31'd0, ($signed(w_a) < $signed(w_b))};
                    6'h2B:        w_alu = {31'd0, (w_a < w_b)};
                    6'h00:        w_alu = w_b << w_sh;
                    6'h02:        w_alu = w_b >> w_sh;
                    6'h03:        w_alu = $unsigned($signed(w_b) >>> w_sh);
                    6'h04:        w_alu = w_b << w_a[4:0];
                    6'h06:        w_alu = w_b >> w_a[4:0];
                    6'h07:        w_alu = $unsigned($signed(w_b) >>> w_a[4:0]);
                    6'h08: begin
                        w_we  = 1'b0;
                        w_npc = w_a;
                    end
                    default:      w_we = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin w_alu = w_a + w_sext; w_we = 1'b1; w_waddr = w_rt; end
            6'h0C: begin w_alu = w_a & w_zext; w_we = 1'b1; w_waddr = w_rt; end
            6'h0D: begin w_alu = w_a | w_zext; w_we = 1'b1; w_waddr = w_rt; end
            6'h0E: begin w_alu = w_a ^ w_zext; w_we = 1'b1; w_waddr = w_rt; end
            6'h0F: begin w_alu = {i_inst[15:0], 16'h0000}; w_we = 1'b1; w_waddr = w_rt; end
            6'h0A: begin w_alu = {31'd0, ($signed(w_a) < $signed(w_sext))}; w_we = 1'b1; w_waddr = w_rt; end
            6'h0B: begin w_alu = {31'd0, (w_a < w_sext)}; w_we = 1'b1; w_waddr = w_rt; end
            6'h23: begin w_alu = w_a + w_sext; w_we = 1'b1; w_waddr = w_rt; w_ld = 1'b1; end
            6'h2B: begin w_alu = w_a + w_sext; w_dm_we = 1'b1; end
            6'h04: if (w_a == w_b) w_npc = w_btgt;
            6'h05: if (w_a != w_b) w_npc = w_btgt;
            6'h02: w_npc = w_jtgt;
            6'h03: begin w_npc = w_jtgt; w_we = 1'b1; w_waddr = 5'd31; w_link = 1'b1; end
            default: ;
        endcase
    end

    assign w_wdata = w_ld ? i_dm_rdata : (w_link ? w_pc4 : w_alu);

    // Program counter: reset to the text base, otherwise follow the next-PC selection
    always_ff @(posedge i_clk) begin
        if (i_rst) r_pc <= TEXT_BASE;
        else       r_pc <= w_npc;
    end

    assign o_pc       = r_pc;
    assign o_alu      = w_alu;
    assign o_dm_we    = w_dm_we;
    assign o_dm_wdata = w_b;
endmodule

module sc_comp_dataflow (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [10:0] dm_addr,
    output logic [10:0] im_addr
);
    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE = 32'h1001_0000;

    // Instruction ROM image is placed here at elaboration by the environment
    logic [31:0] r_imem [0:2047];
    logic [31:0] r_dmem [0:2047];
    logic [31:0] w_alu, w_dm_wdata, w_dm_rdata, w_im_off, w_dm_off;
    logic        w_dm_we, w_unused_bits;

    sc_cpu cpu31 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_inst     (inst),
        .i_dm_rdata (w_dm_rdata),
        .o_pc       (pc),
        .o_alu      (w_alu),
        .o_dm_we    (w_dm_we),
        .o_dm_wdata (w_dm_wdata)
    );

    // Word indices wrap modulo 2048: only offset bits [12:2] survive
    assign w_im_off = pc - TEXT_BASE;
    assign w_dm_off = w_alu - DATA_BASE;
    assign im_addr  = w_im_off[12:2];
    assign dm_addr  = w_dm_off[12:2];
    assign w_unused_bits = ^{w_im_off[31:13], w_im_off[1:0], w_dm_off[31:13], w_dm_off[1:0]};

    assign inst       = r_imem[im_addr];
    assign w_dm_rdata = r_dmem[dm_addr];

    // Word store, suppressed while reset is asserted; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && w_dm_we) r_dmem[dm_addr] <= w_dm_wdata;
    end
endmodule

// File: tb/tb_sc_comp_dataflow.sv
// Bench for sc_comp_dataflow: instruction-set reference model plus directed programs.
module tb_sc_comp_dataflow;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst, pc;
    logic [10:0] dm_addr, im_addr;

    sc_comp_dataflow dut (
        .clk     (clk),
        .rst     (rst),
        .inst    (inst),
        .pc      (pc),
        .dm_addr (dm_addr),
        .im_addr (im_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_im  [0:2047];
    logic [31:0] m_dm  [0:2047];
    logic [31:0] m_reg [0:31];
    logic [31:0] m_pc;
    logic [31:0] prog [$];

    function automatic logic [31:0] enc_r(input int rs, rt, rd, sh, fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_i(input int op, rs, rt, input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction
    function automatic logic [31:0] enc_j(input int op, input logic [25:0] idx);
        return {6'(op), idx};
    endfunction

    function automatic logic [10:0] im_index(input logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'h0040_0000) >> 2;
        return off[10:0];
    endfunction
    function automatic logic [10:0] dm_index(input logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'h1001_0000) >> 2;
        return off[10:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Architectural effect of one clock edge on the model state
    task automatic model_step(input bit r);
        logic [31:0] ins, a, b, se, ze, p4, npc, res, ea;
        logic [5:0]  op, fn;
        logic [4:0]  sh;
        int          dst;
        if (r) begin
            m_pc = 32'h0040_0000;
            for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
            return;
        end
        ins = m_im[im_index(m_pc)];
        op  = ins[31:26];
        fn  = ins[5:0];
        sh  = ins[10:6];
        a   = m_reg[ins[25:21]];
        b   = m_reg[ins[20:16]];
        se  = {{16{ins[15]}}, ins[15:0]};
        ze  = {16'h0, ins[15:0]};
        p4  = m_pc + 32'd4;
        npc = p4;
        ea  = a + se;
        res = 32'd0;
        dst = 0;
        if (op == 6'h00) begin
            dst = int'(ins[15:11]);
            case (fn)
                6'h20, 6'h21: res = a + b;
                6'h22, 6'h23: res = a - b;
                6'h24: res = a & b;
                6'h25: res = a | b;
                6'h26: res = a ^ b;
                6'h27: res = ~(a | b);
                6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                6'h00: res = b << sh;
                6'h02: res = b >> sh;
                6'h03: res = $unsigned($signed(b) >>> sh);
                6'h04: res = b << a[4:0];
                6'h06: res = b >> a[4:0];
                6'h07: res = $unsigned($signed(b) >>> a[4:0]);
                6'h08: begin npc = a; dst = 0; end
                default: dst = 0;
            endcase
        end else begin
            dst = int'(ins[20:16]);
            case (op)
                6'h08, 6'h09: res = ea;
                6'h0C: res = a & ze;
                6'h0D: res = a | ze;
                6'h0E: res = a ^ ze;
                6'h0F: res = ze << 16;
                6'h0A: res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
                6'h0B: res = (a < se) ? 32'd1 : 32'd0;
                6'h23: res = m_dm[dm_index(ea)];
                6'h2B: begin m_dm[dm_index(ea)] = b; dst = 0; end
                6'h04: begin if (a == b) npc = p4 + (se << 2); dst = 0; end
                6'h05: begin if (a != b) npc = p4 + (se << 2); dst = 0; end
                6'h02: begin npc = {p4[31:28], ins[25:0], 2'b00}; dst = 0; end
                6'h03: begin npc = {p4[31:28], ins[25:0], 2'b00}; res = p4; dst = 31; end
                default: dst = 0;
            endcase
        end
        if (dst != 0) m_reg[dst] = res;
        m_pc = npc;
    endtask

    // Compare every observable against the model for the current cycle
    task automatic check_all();
        logic [31:0] ins;
        ins = m_im[im_index(m_pc)];
        chk("pc", pc, m_pc);
        chk("inst", inst, ins);
        chk("im_addr", {21'd0, im_addr}, {21'd0, im_index(m_pc)});
        if (ins[31:26] == 6'h23 || ins[31:26] == 6'h2B)
            chk("dm_addr", {21'd0, dm_addr},
                {21'd0, dm_index(m_reg[ins[25:21]] + {{16{ins[15]}}, ins[15:0]})});
        for (int i = 0; i < 32; i++)
            chk($sformatf("reg%0d", i), dut.cpu31.cpu_ref.array_reg[i], m_reg[i]);
    endtask

    task automatic tick(input bit r);
        rst = r;
        model_step(r);
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] fns [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
        logic [5:0] ops [12] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B,
                                 6'h04, 6'h05, 6'h0A, 6'h0B};
        int k, rs, rt, rd;
        logic [15:0] imm;
        k   = int'($urandom_range(0, 32));
        rs  = int'($urandom_range(0, 7));
        rt  = int'($urandom_range(0, 7));
        rd  = int'($urandom_range(0, 7));
        imm = 16'($urandom);
        if (k < 17)  return enc_r(rs, rt, rd, int'($urandom_range(0, 31)), int'(fns[k]));
        if (k < 29)  return enc_i(int'(ops[k - 17]), rs, rt, imm);
        if (k == 29) return enc_j(2, 26'($urandom));
        if (k == 30) return enc_j(3, 26'($urandom));
        if (k == 31) return 32'hFC00_0000;
        return enc_r(rs, rt, rd, 0, 6'h01);
    endfunction

    task automatic load_prog(input bit rand_fill);
        logic [31:0] w;
        for (int i = 0; i < 2048; i++) begin
            if (i < prog.size()) w = prog[i];
            else if (rand_fill)  w = rand_inst();
            else                 w = 32'd0;
            m_im[i] = w;
            dut.r_imem[i] = w;
        end
        prog.delete();
    endtask

    task automatic pin(input string name, input int r, input logic [31:0] lit);
        chk({name, "_dut"}, dut.cpu31.cpu_ref.array_reg[r], lit);
        chk({name, "_model"}, m_reg[r], lit);
    endtask

    logic [31:0] pc_seq [12] = '{32'h0040_0004, 32'h0040_0008, 32'h0040_000C, 32'h0040_0010,
                                 32'h0040_001C, 32'h0040_0020, 32'h0040_0030, 32'h0040_0024,
                                 32'h0040_0028, 32'h0040_002C, 32'h0040_0030, 32'h0040_0024};

    initial begin
        for (int i = 0; i < 2048; i++) m_dm[i] = 32'd0;

        // Clear data memory with a loop so later loads have known contents
        prog.push_back(enc_i(6'h0F, 0, 1, 16'h1001));
        prog.push_back(enc_i(6'h09, 0, 2, 16'h0800));
        prog.push_back(enc_i(6'h2B, 1, 0, 16'h0000));
        prog.push_back(enc_i(6'h09, 1, 1, 16'h0004));
        prog.push_back(enc_i(6'h09, 2, 2, 16'hFFFF));
        prog.push_back(enc_i(6'h05, 2, 0, 16'hFFFC));
        load_prog(1'b0);
        tick(1'b1);
        chk("reset_pc", pc, 32'h0040_0000);
        chk("reset_im_addr", {21'd0, im_addr}, 32'd0);
        for (int i = 0; i < 32; i++) chk("reset_reg", dut.cpu31.cpu_ref.array_reg[i], 32'd0);
        repeat (8200) tick(1'b0);
        pin("clear_r1", 1, 32'h1001_2000);
        pin("clear_r2", 2, 32'd0);

        // ALU program
        prog.push_back(enc_i(6'h0F, 0, 1, 16'h1234));
        prog.push_back(enc_i(6'h0D, 1, 1, 16'h5678));
        prog.push_back(enc_i(6'h09, 0, 2, 16'hFFFF));
        prog.push_back(enc_r(1, 2, 3, 0, 6'h2B));
        prog.push_back(enc_r(1, 2, 4, 0, 6'h2A));
        prog.push_back(enc_r(0, 2, 5, 4, 6'h03));
        load_prog(1'b0);
        tick(1'b1);
        repeat (6) tick(1'b0);
        pin("alu_r1", 1, 32'h1234_5678);
        pin("alu_r2", 2, 32'hFFFF_FFFF);
        pin("alu_r3", 3, 32'd1);
        pin("alu_r4", 4, 32'd0);
        pin("alu_r5", 5, 32'hFFFF_FFFF);

        // Memory program
        prog.push_back(enc_i(6'h0F, 0, 1, 16'h1001));
        prog.push_back(enc_i(6'h09, 0, 2, 16'h0055));
        prog.push_back(enc_i(6'h2B, 1, 2, 16'h0008));
        prog.push_back(enc_i(6'h23, 1, 3, 16'h0008));
        load_prog(1'b0);
        tick(1'b1);
        repeat (2) tick(1'b0);
        chk("mem_sw_dm_addr", {21'd0, dm_addr}, 32'd2);
        tick(1'b0);
        chk("mem_lw_dm_addr", {21'd0, dm_addr}, 32'd2);
        tick(1'b0);
        pin("mem_r3", 3, 32'h0000_0055);

        // Branch, jump, $0 protection and undefined opcode
        for (int i = 0; i < 4; i++) prog.push_back(32'd0);
        prog.push_back(enc_i(6'h04, 0, 0, 16'h0002));
        prog.push_back(32'd0);
        prog.push_back(32'd0);
        prog.push_back(enc_i(6'h05, 0, 0, 16'h0005));
        prog.push_back(enc_j(3, 26'h010_000C));
        prog.push_back(enc_i(6'h09, 0, 0, 16'h0007));
        prog.push_back(32'hFC00_0000);
        prog.push_back(enc_i(6'h09, 0, 1, 16'h0077));
        prog.push_back(enc_r(31, 0, 0, 0, 6'h08));
        load_prog(1'b0);
        tick(1'b1);
        for (int i = 0; i < 12; i++) begin
            tick(1'b0);
            chk($sformatf("flow_pc%0d", i), pc, pc_seq[i]);
            chk($sformatf("flow_model_pc%0d", i), m_pc, pc_seq[i]);
            if (i == 6) pin("jal_r31", 31, 32'h0040_0024);
            if (i == 8) pin("zero_reg", 0, 32'd0);
        end
        pin("flow_r1", 1, 32'h0000_0077);

        // Reset in the middle of the running loop
        tick(1'b1);
        chk("midrst_pc", pc, 32'h0040_0000);
        pin("midrst_r1", 1, 32'd0);
        pin("midrst_r31", 31, 32'd0);
        prog.push_back(enc_i(6'h0F, 0, 1, 16'h1001));
        prog.push_back(enc_i(6'h23, 1, 4, 16'h0008));
        load_prog(1'b0);
        tick(1'b1);
        repeat (2) tick(1'b0);
        pin("dm_kept_r4", 4, 32'h0000_0055);

        // Random programs with occasional reset
        for (int round = 0; round < 4; round++) begin
            load_prog(1'b1);
            tick(1'b1);
            repeat (1500) tick($urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sc_comp_dataflow.md
# sc_comp_dataflow

Single-cycle 32-bit MIPS subset processor with on-chip instruction and data memories. It is the top-level computer block: fetch, decode, register file, ALU, data memory and next-PC logic, with one instruction completing per clock. It exposes the current PC, the current instruction and both memory word addresses for simulation tracing. The register file is reachable by hierarchy at `cpu31.cpu_ref.array_reg[0..31]` for trace dumps.

## Interface
- No parameters. Fixed values: IM and DM depth 2048 words each, text base 0x0040_0000, data base 0x1001_0000.
- Synchronicity: one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inst  out  32  instruction currently fetched, IM[im_addr], combinational.
- pc  out  32  current program counter.
- dm_addr  out  11  DM word index, ((ALU result − 0x1001_0000) >> 2)[10:0].
- im_addr  out  11  IM word index, ((pc − 0x0040_0000) >> 2)[10:0].

## Operation
- Hierarchy: processor instance `cpu31`, register file instance `cpu_ref` inside it, storage `array_reg[31:0]` of 32×32 bits.
- IM is a 2048×32 ROM loaded at elaboration from a hex program image. Reads are asynchronous.
- DM is a 2048×32 RAM. Reads are asynchronous; writes are synchronous, word-only. DM is not cleared by reset.
- Register file:
  - Two asynchronous read ports, one synchronous write port.
  - $0 always reads 0; writes to $0 are discarded.
  - rst clears all 32 registers to 0.
- Supported instructions (31). Any other encoding executes as a NOP: PC+4, no writes.
  - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, jr.
  - I-type: addi, addiu, andi, ori, xori, lui, lw, sw, beq, bne, slti, sltiu.
  - J-type: j, jal.
- Arithmetic rules:
  - add/addi/sub behave exactly like addu/addiu/subu. No overflow trap.
  - addi, addiu, slti, sltiu, lw, sw, beq and bne sign-extend imm16. andi, ori and xori zero-extend it.
  - lui writes {imm16, 16'h0}.
  - slt/slti compare signed; sltu/sltiu compare unsigned after extension. The result is 0 or 1.
  - Shifts use shamt (sll/srl/sra) or rs[4:0] (sllv/srlv/srav). sra/srav are arithmetic.
- Next PC (no delay slots):
  - Default: PC+4.
  - beq/bne taken: PC+4+(sext(imm16)<<2).
  - j/jal: {PC+4[31:28], index26, 2'b00}.
  - jr: rs.
  - jal writes PC+4 to $31.
- Memory addressing: lw/sw effective address is rs+sext(imm16), mapped to dm_addr as defined in the Interface. Upper bits beyond 11 are truncated, so accesses wrap modulo 2048 words. im_addr wraps the same way.

## Timing
- Single cycle: a rising edge commits PC, register write and DM write simultaneously, for the instruction presented during the preceding cycle.
- The register write and the DM write each take effect at that edge. A read of the same register by the next instruction sees the new value.
- Reset:
  - rst sampled high at a rising edge sets pc to 0x0040_0000 and clears the register file.
  - After that edge: im_addr = 0 and inst = IM[0].
  - While rst is high, no DM write and no register write other than the clear occurs.
  - Reset asserted mid-program takes effect at the next edge, regardless of the instruction in flight. DM keeps its contents.
- All outputs are combinational from state. They settle within the cycle and are valid for sampling on the falling edge.

## Test plan
- Reset: hold rst for one rising edge → pc=0x0040_0000, im_addr=0, all array_reg=0. Release → pc advances by 4 each cycle through NOPs.
- ALU: `lui $1,0x1234; ori $1,$1,0x5678; addiu $2,$0,-1; sltu $3,$1,$2; slt $4,$1,$2; sra $5,$2,4` → $1=0x12345678, $2=0xFFFFFFFF, $3=1, $4=0, $5=0xFFFFFFFF.
- Memory: `lui $1,0x1001; addiu $2,$0,0x55; sw $2,8($1); lw $3,8($1)` → dm_addr=2 during both, $3=0x00000055.
- Branch/jump:
  - `beq $0,$0,+2` at 0x0040_0010 → next pc=0x0040_001C.
  - bne on equal operands → pc+4.
  - `jal` at 0x0040_0020 → $31=0x0040_0024.
  - `jr $31` → returns to 0x0040_0024.
- $0 protection: `addiu $0,$0,7` → $0 remains 0. Undefined opcode 0xFC000000 → no register change, pc+4.
- Mid-run reset after $1 has been written → next edge pc=0x0040_0000, $1=0; a previously stored DM word is still readable by lw.
